// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one outstanding 64-bit imem read per PC, 32-bit word select,
// output hold until decode accepts, and flush handling that drops late responses.
module ifu_fetch (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] pc_i,
    input  logic        flush_i,
    output logic        pc_stall_o,
    output logic        imem_req_o,
    output logic [63:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [63:0] imem_rdata_i,
    input  logic        imem_rerr_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [63:0] inst_pc_o,
    output logic        inst_fault_o,
    input  logic        id_ready_i
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DROP} state_t;

    state_t      state;
    state_t      next_state;
    logic [63:0] fetch_pc;
    logic        drop_pend;
    logic [31:0] inst_q;
    logic        fault_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (!flush_i) begin
                    next_state = (pc_i[1:0] != 2'b00) ? HOLD : REQ;
                end
            end
            REQ: begin
                if (imem_gnt_i) begin
                    next_state = (drop_pend || flush_i) ? DROP : WAIT;
                end
            end
            WAIT: begin
                // A response arriving with the flush has already retired the bus slot.
                if (flush_i) begin
                    next_state = imem_rvalid_i ? IDLE : DROP;
                end else if (imem_rvalid_i) begin
                    next_state = HOLD;
                end
            end
            HOLD: begin
                if (id_ready_i || flush_i) begin
                    next_state = IDLE;
                end
            end
            DROP: begin
                if (imem_rvalid_i) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc  <= '0;
            drop_pend <= 1'b0;
            inst_q    <= '0;
            fault_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!flush_i) begin
                        fetch_pc <= pc_i;
                        if (pc_i[1:0] != 2'b00) begin
                            inst_q  <= NOP;
                            fault_q <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (flush_i && !imem_gnt_i) begin
                        drop_pend <= 1'b1;
                    end
                end
                WAIT: begin
                    if (imem_rvalid_i && !flush_i) begin
                        if (imem_rerr_i) begin
                            inst_q <= NOP;
                        end else begin
                            inst_q <= fetch_pc[2] ? imem_rdata_i[63:32] : imem_rdata_i[31:0];
                        end
                        fault_q <= imem_rerr_i;
                    end
                end
                HOLD: begin
                    if (id_ready_i || flush_i) begin
                        inst_q  <= '0;
                        fault_q <= 1'b0;
                    end
                end
                DROP: begin
                    if (imem_rvalid_i) begin
                        drop_pend <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        imem_req_o   = (state == REQ);
        imem_addr_o  = (state == REQ) ? {fetch_pc[63:3], 3'b000} : '0;
        inst_valid_o = (state == HOLD);
        inst_pc_o    = (state == HOLD) ? fetch_pc : '0;
        pc_stall_o   = !((state == HOLD) && id_ready_i);
    end

    assign inst_o       = inst_q;
    assign inst_fault_o = fault_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Testbench for ifu_fetch: PC stage and memory responder models around the DUT,
// directed scenarios followed by a randomized phase checked against a fetch-level model.
module tb_ifu_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] pc_i;
    logic        flush_i;
    logic        pc_stall_o;
    logic        imem_req_o;
    logic [63:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [63:0] imem_rdata_i;
    logic        imem_rerr_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [63:0] inst_pc_o;
    logic        inst_fault_o;
    logic        id_ready_i;

    always #5 clk = ~clk;

    ifu_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .pc_i         (pc_i),
        .flush_i      (flush_i),
        .pc_stall_o   (pc_stall_o),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_gnt_i   (imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i (imem_rdata_i),
        .imem_rerr_i  (imem_rerr_i),
        .inst_valid_o (inst_valid_o),
        .inst_o       (inst_o),
        .inst_pc_o    (inst_pc_o),
        .inst_fault_o (inst_fault_o),
        .id_ready_i   (id_ready_i)
    );

    int compared   = 0;
    int mismatched = 0;

    // Environment state: PC stage, memory responder and directed-step controls.
    logic [63:0] pc_model;
    logic [63:0] flush_tgt;
    logic [63:0] cur_tgt;
    logic [63:0] resp_addr;
    bit          busy;
    bit          resp_err;
    bit          last_err;
    bit          err_next;
    bit          rand_mode;
    bit          rst_cmd;
    bit          ready_cmd;
    bit          flush_cmd;
    int          cnt;
    int          gnt_wait;
    int          gnt_delay;
    int          mem_lat;
    int          handoffs;

    // Values seen just before the most recent rising edge.
    bit          rst_q;
    bit          req_q;
    bit          gnt_q;
    bit          rvalid_q;
    bit          stall_q;
    bit          flush_q;
    bit          valid_q;
    bit          handoff_q;
    logic [63:0] tgt_q;
    logic [63:0] addr_q;
    logic [31:0] prev_inst;

    function automatic logic [63:0] memWord(input logic [63:0] a);
        if (a == 64'h8000_0000) return 64'h0000_0013_0010_0093;
        return {a[31:0] ^ 32'hC0DE_0000, ~a[31:0] + 32'h0000_1111};
    endfunction

    function automatic logic [31:0] expInst(input logic [63:0] pc, input bit err);
        logic [63:0] w;
        if (pc[1:0] != 2'b00 || err) return 32'h0000_0013;
        w = memWord({pc[63:3], 3'b000});
        return pc[2] ? w[63:32] : w[31:0];
    endfunction

    function automatic logic [63:0] randTarget();
        logic [63:0] t;
        t = 64'h8000_0000 + 64'($urandom_range(0, 1023)) * 64'd4;
        if ($urandom % 8 == 0) t = t + 64'd2;
        return t;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance the environment models over the edge just taken, then drive this cycle's inputs.
    task automatic applyStimulus();
        if (rst_q) begin
            busy     = 1'b0;
            gnt_wait = 0;
        end else begin
            if (flush_q) pc_model = tgt_q;
            else if (!stall_q) pc_model = pc_model + 64'd4;
            if (rvalid_q) busy = 1'b0;
            else if (busy && cnt > 0) cnt--;
            if (req_q && gnt_q) begin
                if (rand_mode) begin
                    mem_lat   = $urandom_range(1, 3);
                    gnt_delay = $urandom_range(0, 3);
                    resp_err  = ($urandom % 6 == 0);
                end else begin
                    resp_err = err_next;
                    err_next = 1'b0;
                end
                busy      = 1'b1;
                cnt       = mem_lat - 1;
                resp_addr = addr_q;
            end
            if (req_q && !gnt_q) gnt_wait++;
            else gnt_wait = 0;
        end
        rst = rst_cmd;
        if (rst_cmd) busy = 1'b0;
        pc_i          = pc_model;
        imem_rvalid_i = busy && (cnt == 0);
        imem_rdata_i  = imem_rvalid_i ? memWord(resp_addr) : 64'hDEAD_BEEF_0BAD_F00D;
        imem_rerr_i   = imem_rvalid_i && resp_err;
        if (imem_rvalid_i) last_err = resp_err;
        imem_gnt_i    = !rst_cmd && (imem_req_o === 1'b1) && (gnt_wait >= gnt_delay);
        if (rand_mode) begin
            id_ready_i = ($urandom % 3 != 0);
            flush_i    = ($urandom % 20 == 0);
            if (flush_i) cur_tgt = randTarget();
        end else begin
            id_ready_i = ready_cmd;
            flush_i    = flush_cmd;
            cur_tgt    = flush_tgt;
            flush_cmd  = 1'b0;
        end
    endtask

    task automatic monitor();
        if (rst === 1'b1) return;
        checkOutput("stall_rule", 64'(pc_stall_o), 64'(!(inst_valid_o && id_ready_i)));
        if (inst_valid_o === 1'b1) begin
            checkOutput("hold_pc", inst_pc_o, pc_model);
            checkOutput("hold_inst", 64'(inst_o), 64'(expInst(pc_model, last_err)));
            checkOutput("hold_fault", 64'(inst_fault_o), 64'((pc_model[1:0] != 2'b00) || last_err));
            if (rand_mode && id_ready_i) handoffs++;
        end else begin
            checkOutput("clear_pc", inst_pc_o, 64'd0);
            checkOutput("clear_inst", 64'({inst_fault_o, inst_o}), 64'd0);
        end
        if (!rst_q && valid_q && !handoff_q && !flush_q) begin
            checkOutput("hold_stable_valid", 64'(inst_valid_o), 64'd1);
            checkOutput("hold_stable_inst", 64'(inst_o), 64'(prev_inst));
        end
        if (imem_req_o === 1'b1) begin
            checkOutput("req_single", 64'(busy), 64'd0);
            if (!rst_q && req_q && !gnt_q) begin
                checkOutput("addr_stable", imem_addr_o, addr_q);
            end else begin
                checkOutput("addr_new", imem_addr_o, {pc_model[63:3], 3'b000});
                checkOutput("req_aligned", 64'(pc_model[1:0]), 64'd0);
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        applyStimulus();
        @(negedge clk);
        monitor();
        rst_q     = rst;
        req_q     = imem_req_o;
        gnt_q     = imem_gnt_i;
        rvalid_q  = imem_rvalid_i;
        stall_q   = pc_stall_o;
        flush_q   = flush_i;
        tgt_q     = cur_tgt;
        addr_q    = imem_addr_o;
        valid_q   = inst_valid_o;
        handoff_q = inst_valid_o && id_ready_i;
        prev_inst = inst_o;
    endtask

    task automatic waitValid(input string tag);
        int n = 0;
        while (inst_valid_o !== 1'b1 && n < 40) begin
            cycle();
            n++;
        end
        checkOutput({tag, "_valid_reached"}, 64'(inst_valid_o), 64'd1);
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_req"}, 64'(imem_req_o), 64'd0);
        checkOutput({tag, "_addr"}, imem_addr_o, 64'd0);
        checkOutput({tag, "_valid"}, 64'(inst_valid_o), 64'd0);
        checkOutput({tag, "_inst"}, 64'(inst_o), 64'd0);
        checkOutput({tag, "_pc"}, inst_pc_o, 64'd0);
        checkOutput({tag, "_fault"}, 64'(inst_fault_o), 64'd0);
        checkOutput({tag, "_stall"}, 64'(pc_stall_o), 64'd1);
    endtask

    initial begin
        int idle;
        rst = 1'b1; pc_i = '0; flush_i = 1'b0; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0;
        imem_rdata_i = '0; imem_rerr_i = 1'b0; id_ready_i = 1'b0;
        pc_model = 64'h8000_0000; flush_tgt = '0; cur_tgt = '0; resp_addr = '0;
        busy = 0; resp_err = 0; last_err = 0; err_next = 0; rand_mode = 0;
        rst_cmd = 1; ready_cmd = 1; flush_cmd = 0; cnt = 0; gnt_wait = 0;
        gnt_delay = 0; mem_lat = 1; handoffs = 0;
        rst_q = 1; req_q = 0; gnt_q = 0; rvalid_q = 0; stall_q = 1; flush_q = 0;
        valid_q = 0; handoff_q = 0; tgt_q = '0; addr_q = '0; prev_inst = '0;

        $display("[TB] reset");
        cycle(); cycle();
        checkReset("rst");

        $display("[TB] basic fetch, zero-wait memory");
        rst_cmd = 0;
        cycle();
        checkOutput("t0_req", 64'(imem_req_o), 64'd0);
        checkOutput("t0_stall", 64'(pc_stall_o), 64'd1);
        cycle();
        checkOutput("t1_req", 64'(imem_req_o), 64'd1);
        checkOutput("t1_addr", imem_addr_o, 64'h8000_0000);
        cycle();
        checkOutput("t2_valid", 64'(inst_valid_o), 64'd0);
        cycle();
        checkOutput("t3_valid", 64'(inst_valid_o), 64'd1);
        checkOutput("t3_inst", 64'(inst_o), 64'h0010_0093);
        checkOutput("t3_pc", inst_pc_o, 64'h8000_0000);
        checkOutput("t3_stall", 64'(pc_stall_o), 64'd0);
        cycle();
        checkOutput("t4_stall", 64'(pc_stall_o), 64'd1);
        cycle(); cycle(); cycle();
        checkOutput("t7_valid", 64'(inst_valid_o), 64'd1);
        checkOutput("t7_inst", 64'(inst_o), 64'h0000_0013);
        checkOutput("t7_pc", inst_pc_o, 64'h8000_0004);

        $display("[TB] backpressure");
        ready_cmd = 0;
        cycle();
        waitValid("bp");
        for (int k = 0; k < 5; k++) begin
            checkOutput("bp_valid", 64'(inst_valid_o), 64'd1);
            checkOutput("bp_inst", 64'(inst_o), 64'(expInst(64'h8000_0008, 1'b0)));
            checkOutput("bp_stall", 64'(pc_stall_o), 64'd1);
            checkOutput("bp_req", 64'(imem_req_o), 64'd0);
            cycle();
        end
        ready_cmd = 1;
        cycle();
        checkOutput("bp_release_stall", 64'(pc_stall_o), 64'd0);
        checkOutput("bp_release_pc", inst_pc_o, 64'h8000_0008);

        $display("[TB] grant stall with flush");
        gnt_delay = 3;
        cycle();
        flush_cmd = 1; flush_tgt = 64'h8000_1000;
        cycle();
        checkOutput("gs_req", 64'(imem_req_o), 64'd1);
        checkOutput("gs_addr", imem_addr_o, 64'h8000_0008);
        for (int k = 0; k < 3; k++) begin
            cycle();
            checkOutput("gs_req_hold", 64'(imem_req_o), 64'd1);
            checkOutput("gs_addr_hold", imem_addr_o, 64'h8000_0008);
        end
        gnt_delay = 0;
        cycle();
        checkOutput("gs_drop_valid", 64'(inst_valid_o), 64'd0);
        checkOutput("gs_drop_req", 64'(imem_req_o), 64'd0);
        cycle(); cycle();
        checkOutput("gs_new_req", 64'(imem_req_o), 64'd1);
        checkOutput("gs_new_addr", imem_addr_o, 64'h8000_1000);
        waitValid("gs");
        checkOutput("gs_pc", inst_pc_o, 64'h8000_1000);

        $display("[TB] flush in WAIT with coincident rvalid");
        cycle(); cycle();
        checkOutput("fw_req", 64'(imem_req_o), 64'd1);
        flush_cmd = 1; flush_tgt = 64'h8000_2000;
        cycle();
        checkOutput("fw_valid", 64'(inst_valid_o), 64'd0);
        cycle();
        checkOutput("fw_idle_req", 64'(imem_req_o), 64'd0);
        cycle();
        checkOutput("fw_req2", 64'(imem_req_o), 64'd1);
        checkOutput("fw_addr2", imem_addr_o, 64'h8000_2000);

        $display("[TB] bus error");
        err_next = 1;
        waitValid("be");
        checkOutput("be_fault", 64'(inst_fault_o), 64'd1);
        checkOutput("be_inst", 64'(inst_o), 64'h0000_0013);
        checkOutput("be_pc", inst_pc_o, 64'h8000_2000);

        $display("[TB] misaligned pc");
        flush_cmd = 1; flush_tgt = 64'h8000_0002;
        cycle();
        cycle();
        checkOutput("ma_req", 64'(imem_req_o), 64'd0);
        cycle();
        checkOutput("ma_valid", 64'(inst_valid_o), 64'd1);
        checkOutput("ma_fault", 64'(inst_fault_o), 64'd1);
        checkOutput("ma_inst", 64'(inst_o), 64'h0000_0013);
        checkOutput("ma_pc", inst_pc_o, 64'h8000_0002);
        checkOutput("ma_req_hold", 64'(imem_req_o), 64'd0);

        $display("[TB] reset in WAIT");
        flush_cmd = 1; flush_tgt = 64'h8000_3000;
        cycle();
        mem_lat = 3;
        cycle(); cycle();
        checkOutput("rw_req", 64'(imem_req_o), 64'd1);
        cycle();
        checkOutput("rw_wait_req", 64'(imem_req_o), 64'd0);
        checkOutput("rw_wait_valid", 64'(inst_valid_o), 64'd0);
        rst_cmd = 1;
        cycle(); cycle();
        checkReset("rw");
        rst_cmd = 0; mem_lat = 1;

        $display("[TB] randomized traffic");
        rand_mode = 1;
        idle = 0;
        for (int i = 0; i < 2000; i++) begin
            cycle();
            if (inst_valid_o === 1'b1) idle = 0;
            else idle++;
            if (idle > 200) begin
                checkOutput("rand_progress", 64'(inst_valid_o), 64'd1);
                idle = 0;
            end
        end
        checkOutput("rand_handoffs", 64'(handoffs >= 50), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
